// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if: configuration bus for clk_en_gen.
//   cfg_we      - single-cycle configuration write strobe
//   cfg_ch      - target channel of the write (values >= NUM_CH are ignored)
//   cfg_div     - new divide ratio N (0 is treated as 1)
//   cfg_pending - per-channel flag: a shadow ratio is waiting for terminal count
// master: software/config side, slave: clk_en_gen.
interface clk_en_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] cfg_pending;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        input  cfg_pending
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        output cfg_pending
    );
endinterface

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel runtime-programmable clock-enable / divided-clock
// generator. Each channel counts 0..Neff-1 (Neff = max(div,1)), emits a
// one-cycle tick at terminal count and a registered square wave that is high
// for ceil(N/2) cycles, low for floor(N/2), rising together with tick.
// Ratio changes on a running channel are shadowed and applied only at
// terminal count, so periods are never shortened.
//   clk      - system clock
//   rst_n    - synchronous active-low reset
//   run_en   - per-channel run enable (0 = hold count and clk_out)
//   sync_clr - restart all counters at once (phase alignment)
//   cfg      - configuration bus (clk_en_gen_if.slave)
//   tick     - per-channel clock-enable pulse
//   clk_out  - per-channel divided clock
module clk_en_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] run_en,
    input  logic              sync_clr,
    clk_en_gen_if.slave       cfg,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = 1;
    localparam logic [DIV_W:0]   ONE_X   = 1;

    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [DIV_W-1:0]  div_q    [NUM_CH];
    logic [DIV_W-1:0]  div_d    [NUM_CH];
    logic [DIV_W-1:0]  div_sh_q [NUM_CH];
    logic [DIV_W-1:0]  div_sh_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q,    pend_d;
    logic [NUM_CH-1:0] tick_q,    tick_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] wr_hit;

    // Effective ratio: a programmed 0 behaves as 1.
    function automatic logic [DIV_W-1:0] neff(input logic [DIV_W-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    // ceil(Neff/2), one bit wider so Neff = 2^DIV_W-1 cannot overflow.
    function automatic logic [DIV_W:0] half_hi(input logic [DIV_W-1:0] d);
        logic [DIV_W:0] n;
        n = {1'b0, neff(d)};
        return (n + ONE_X) >> 1;
    endfunction

    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            wr_hit[ch]    = cfg.cfg_we && (cfg.cfg_ch == 4'(ch));
            cnt_d[ch]     = cnt_q[ch];
            div_d[ch]     = div_q[ch];
            div_sh_d[ch]  = div_sh_q[ch];
            pend_d[ch]    = pend_q[ch];
            tick_d[ch]    = 1'b0;
            clk_out_d[ch] = clk_out_q[ch];

            if (sync_clr) begin
                // Global restart: flush any shadow, a same-cycle write lands directly.
                cnt_d[ch]     = '0;
                clk_out_d[ch] = 1'b1;
                pend_d[ch]    = 1'b0;
                if (pend_q[ch]) begin
                    div_d[ch] = div_sh_q[ch];
                end
                if (wr_hit[ch]) begin
                    div_d[ch] = cfg.cfg_div;
                end
            end else if (run_en[ch]) begin
                if (cnt_q[ch] == neff(div_q[ch]) - ONE) begin
                    cnt_d[ch]  = '0;
                    tick_d[ch] = 1'b1;
                    if (pend_q[ch]) begin
                        div_d[ch]  = div_sh_q[ch];
                        pend_d[ch] = 1'b0;
                    end
                end else begin
                    cnt_d[ch] = cnt_q[ch] + ONE;
                end
                // A write at terminal count still applies the old shadow above;
                // the new value then waits for the following period.
                if (wr_hit[ch]) begin
                    div_sh_d[ch] = cfg.cfg_div;
                    pend_d[ch]   = 1'b1;
                end
                clk_out_d[ch] = ({1'b0, cnt_d[ch]} < half_hi(div_d[ch]));
            end else if (wr_hit[ch]) begin
                // Stopped channel: no period in flight, apply immediately.
                div_d[ch]  = cfg.cfg_div;
                cnt_d[ch]  = '0;
                pend_d[ch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]    <= '0;
                div_q[ch]    <= DEF_DIV;
                div_sh_q[ch] <= DEF_DIV;
            end
            pend_q    <= '0;
            tick_q    <= '0;
            clk_out_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]    <= cnt_d[ch];
                div_q[ch]    <= div_d[ch];
                div_sh_q[ch] <= div_sh_d[ch];
            end
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick            = tick_q;
    assign clk_out         = clk_out_q;
    assign cfg.cfg_pending = pend_q;

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] run_en;
    logic       sync_clr;
    logic [3:0] tick;
    logic [3:0] clk_out;

    int n_checks = 0;
    int n_errors = 0;

    clk_en_gen_if #(.NUM_CH(4), .DIV_W(16)) cfg_bus ();

    clk_en_gen #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_en   (run_en),
        .sync_clr (sync_clr),
        .cfg      (cfg_bus),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  run;
        logic        sclr;
        logic        we;
        logic [3:0]  ch;
        logic [15:0] div;
        logic [3:0]  e_tick;
        logic [3:0]  e_clk;
        logic [3:0]  e_pend;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sync_clr        = 1'b0;
        cfg_bus.cfg_we  = 1'b0;
        cfg_bus.cfg_ch  = 4'h0;
        cfg_bus.cfg_div = 16'h0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        run_en = 4'h0;
        idle_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [15:0] div);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = ch;
        cfg_bus.cfg_div = div;
    endtask

    initial begin
        int coincident;
        logic [3:0] et, ec;

        // ch0 runs at 8; write 3 at cnt=2; write to nonexistent channel 4;
        // pending 4 then a write of 5 landing exactly on terminal count.
        tbl[0]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h0};
        tbl[1]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h0};
        tbl[2]  = '{4'h1, 1'b0, 1'b1, 4'h0, 16'd3, 4'h0, 4'h1, 4'h1};
        tbl[3]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h1};
        tbl[4]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h1};
        tbl[5]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h1};
        tbl[6]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h1};
        tbl[7]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h1, 4'h1, 4'h0};
        tbl[8]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h0};
        tbl[9]  = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h1, 4'h1, 4'h0};
        tbl[11] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h0};
        tbl[12] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h1, 4'h1, 4'h0};
        tbl[14] = '{4'h1, 1'b0, 1'b1, 4'h4, 16'd9, 4'h0, 4'h1, 4'h0};
        tbl[15] = '{4'h1, 1'b0, 1'b1, 4'h0, 16'd4, 4'h0, 4'h0, 4'h1};
        tbl[16] = '{4'h1, 1'b0, 1'b1, 4'h0, 16'd5, 4'h1, 4'h1, 4'h1};
        tbl[17] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h1};
        tbl[18] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h1};
        tbl[19] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h1};
        tbl[20] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h1, 4'h1, 4'h0};
        tbl[21] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h0};
        tbl[22] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h1, 4'h0};
        tbl[23] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h0};
        tbl[24] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h0, 4'h0, 4'h0};
        tbl[25] = '{4'h1, 1'b0, 1'b0, 4'h0, 16'd0, 4'h1, 4'h1, 4'h0};

        // Reset wins over running channels and a concurrent write.
        rst_n  = 1'b0;
        run_en = 4'hF;
        idle_inputs();
        wr(4'h1, 16'd3);
        step();
        step();
        chk("reset tick", tick, 4'h0);
        chk("reset clk_out", clk_out, 4'h0);
        chk("reset pending", cfg_bus.cfg_pending, 4'h0);

        // Table-driven ratio-change sequence.
        rst_n  = 1'b1;
        for (int i = 0; i < 26; i++) begin
            run_en          = tbl[i].run;
            sync_clr        = tbl[i].sclr;
            cfg_bus.cfg_we  = tbl[i].we;
            cfg_bus.cfg_ch  = tbl[i].ch;
            cfg_bus.cfg_div = tbl[i].div;
            step();
            chk($sformatf("tbl[%0d] tick", i), tick, tbl[i].e_tick);
            chk($sformatf("tbl[%0d] clk_out", i), clk_out, tbl[i].e_clk);
            chk($sformatf("tbl[%0d] pending", i), cfg_bus.cfg_pending, tbl[i].e_pend);
        end

        // Default ratio 8 on all channels.
        do_reset();
        run_en = 4'hF;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("def8 k=%0d tick", k), tick, (k % 8 == 0) ? 4'hF : 4'h0);
            chk($sformatf("def8 k=%0d clk_out", k), clk_out, ((k % 8) < 4) ? 4'hF : 4'h0);
        end

        // Ratios 0 and 1 on stopped channels, then run.
        do_reset();
        wr(4'h1, 16'd0);
        step();
        chk("div0 stopped pending", cfg_bus.cfg_pending, 4'h0);
        chk("div0 stopped clk_out", clk_out, 4'h0);
        wr(4'h2, 16'd1);
        step();
        chk("div1 stopped pending", cfg_bus.cfg_pending, 4'h0);
        idle_inputs();
        run_en = 4'b0110;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("n1 k=%0d tick", k), tick, 4'b0110);
            chk($sformatf("n1 k=%0d clk_out", k), clk_out, 4'b0110);
        end

        // N=5 and N=7 phase-aligned by sync_clr; ch2/3 stopped.
        do_reset();
        wr(4'h0, 16'd5);
        step();
        wr(4'h1, 16'd7);
        step();
        idle_inputs();
        run_en = 4'b0011;
        step();
        step();
        step();
        sync_clr = 1'b1;
        step();
        chk("sync tick", tick, 4'h0);
        chk("sync clk_out", clk_out, 4'hF);
        sync_clr   = 1'b0;
        coincident = 0;
        for (int k = 1; k <= 70; k++) begin
            step();
            et = {2'b00, (k % 7 == 0), (k % 5 == 0)};
            ec = {2'b11, ((k % 7) < 4), ((k % 5) < 3)};
            chk($sformatf("5/7 k=%0d tick", k), tick, et);
            chk($sformatf("5/7 k=%0d clk_out", k), clk_out, ec);
            if (tick[1:0] == 2'b11) coincident++;
        end
        n_checks++;
        if (coincident != 2) begin
            n_errors++;
            $display("FAIL coincident ticks: got %0d expected 2", coincident);
        end

        // sync_clr flushes a pending shadow and applies a same-cycle write.
        wr(4'h0, 16'd2);
        step();
        chk("pend before sync", cfg_bus.cfg_pending, 4'h1);
        sync_clr = 1'b1;
        wr(4'h1, 16'd3);
        step();
        chk("pend after sync", cfg_bus.cfg_pending, 4'h0);
        chk("sync2 clk_out", clk_out, 4'hF);
        idle_inputs();
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("2/3 k=%0d tick", k), tick, {2'b00, (k % 3 == 0), (k % 2 == 0)});
        end

        // Reset mid-period with a pending write reverts to DEFAULT_DIV.
        run_en = 4'h1;
        wr(4'h0, 16'd3);
        step();
        chk("pend before reset", cfg_bus.cfg_pending, 4'h1);
        idle_inputs();
        rst_n = 1'b0;
        step();
        chk("midreset tick", tick, 4'h0);
        chk("midreset clk_out", clk_out, 4'h0);
        chk("midreset pending", cfg_bus.cfg_pending, 4'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post-reset k=%0d tick", k), tick, (k == 8) ? 4'h1 : 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
